// File: rtl/laser_arbiter_if.sv
// Request/grant bundle between the laser requesters and the arbiter.
// Master side issues requests and burst timing; slave side is the arbiter.
interface laser_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0] Req;
    logic [CNT_W-1:0] OnTime;
    logic [CNT_W-1:0] CoolTime;
    logic             X;
    logic [N_REQ-1:0] Grant;
    logic             Busy;
    logic             Done;

    modport master (output Req, OnTime, CoolTime, input X, Grant, Busy, Done);
    modport slave  (input Req, OnTime, CoolTime, output X, Grant, Busy, Done);
endinterface

// File: rtl/laser_arbiter.sv
// Round-robin owner of the laser enable X: grant one cycle after Req is seen idle, then on-time burst and cool-down.
// No backpressure: requesters hold Req level until their Grant bit shows; Req is only sampled while idle.
module laser_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    laser_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_Idle = 2'd0;
    localparam logic [1:0] S_Fire = 2'd1;
    localparam logic [1:0] S_Cool = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cool_l;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             x_q;
    logic             busy_q;
    logic             done_q;
    logic [N_REQ-1:0] grant_q;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'(v % N_REQ);
    endfunction

    // Scan from the far end so the requester closest to ptr wins by last assignment.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.Req[wrap_idx(int'(ptr) + i)]) begin
                win   = wrap_idx(int'(ptr) + i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S_Idle;
            cnt     <= '0;
            cool_l  <= '0;
            ptr     <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_Idle: begin
                    if (found) begin
                        state   <= S_Fire;
                        x_q     <= 1'b1;
                        busy_q  <= 1'b1;
                        grant_q <= N_REQ'(1) << win;
                        cnt     <= (bus.OnTime == '0) ? '0 : bus.OnTime - CNT_W'(1);
                        cool_l  <= bus.CoolTime;
                        ptr     <= wrap_idx(int'(win) + 1);
                    end else begin
                        x_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                    end
                end
                S_Fire: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        x_q     <= 1'b0;
                        grant_q <= '0;
                        done_q  <= 1'b1;
                        if (cool_l == '0) begin
                            state  <= S_Idle;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_Cool;
                            cnt   <= cool_l - CNT_W'(1);
                        end
                    end
                end
                S_Cool: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= S_Idle;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_Idle;
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.X     = x_q;
    assign bus.Grant = grant_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
endmodule

// File: tb/tb_laser_arbiter.sv
// Scoreboard bench for laser_arbiter: burst-level reference model feeds an expectation queue,
// an independent monitor checks owner, burst length, Done pulse, Busy length and X-low gaps.
module tb_laser_arbiter;
    localparam int N  = 4;
    localparam int CW = 4;

    logic Clk = 1'b0;
    logic Rst;

    laser_arbiter_if #(.N_REQ(N), .CNT_W(CW)) bus();

    laser_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [N-1:0] mask;
        int           on;
        int           cool;
    } stim_t;

    typedef struct {
        int owner;
        int xlen;
        int cool;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    mptr       = 0;
    int    compared   = 0;
    int    mismatched = 0;
    bit    rst_q      = 1'b0;

    always @(posedge Clk) rst_q <= Rst;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the winner is the first requesting index at or after the rotating pointer.
    function automatic void model_push(input stim_t s);
        exp_t e;
        e.owner = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (mptr + i) % N;
            if (s.mask[j] && e.owner < 0) e.owner = j;
        end
        mptr   = (e.owner + 1) % N;
        e.xlen = (s.on == 0) ? 1 : s.on;
        e.cool = s.cool;
        eq.push_back(e);
    endfunction

    task automatic add(input logic [N-1:0] m, input int on, input int cool);
        stim_t s;
        s.mask = m;
        s.on   = on;
        s.cool = cool;
        sq.push_back(s);
    endtask

    task automatic wait_x(input logic val);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (bus.X !== val && n < 300);
        if (bus.X !== val) chk("wait_x_timeout", int'(bus.X), int'(val));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((bus.X !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) && n < 300);
        if (bus.Busy !== 1'b0) chk("wait_idle_timeout", int'(bus.Busy), 0);
        repeat (2) @(negedge Clk);
    endtask

    // Each queued entry is driven while the previous burst is firing, so it is seen at the next idle cycle.
    task automatic run_seq();
        stim_t s;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge Clk); #1;
            bus.Req      = s.mask;
            bus.OnTime   = CW'(s.on);
            bus.CoolTime = CW'(s.cool);
            model_push(s);
            wait_x(1'b0);
            wait_x(1'b1);
        end
        @(posedge Clk); #1;
        bus.Req = '0;
        wait_idle();
    endtask

    // Monitor
    bit   in_x = 1'b0, bt = 1'b0, had = 1'b0;
    int   xcnt = 0, busy_cnt = 0, gap = 0, last_cool = 0;
    exp_t cur = '{owner: 0, xlen: 0, cool: 0};

    always @(negedge Clk) begin : monitor
        bit rise, fell;
        if (rst_q) begin
            chk("rst_x", int'(bus.X), 0);
            chk("rst_grant", int'(bus.Grant), 0);
            chk("rst_busy", int'(bus.Busy), 0);
            chk("rst_done", int'(bus.Done), 0);
            in_x = 1'b0;
            bt   = 1'b0;
            had  = 1'b0;
        end else begin
            rise = bus.X && !in_x;
            fell = !bus.X && in_x;
            chk("grant_shape", bus.X ? int'($onehot(bus.Grant)) : int'(bus.Grant == '0), 1);
            chk("done_pulse", int'(bus.Done), int'(fell));
            if (rise) begin
                if (eq.size() == 0) begin
                    chk("unexpected_burst", 1, 0);
                end else begin
                    cur = eq.pop_front();
                    chk("grant_owner", int'(bus.Grant), 1 << cur.owner);
                end
                if (had) chk("gap_min", int'(gap >= last_cool + 1), 1);
                in_x     = 1'b1;
                xcnt     = 0;
                bt       = 1'b1;
                busy_cnt = 0;
            end else if (bus.X) begin
                chk("grant_hold", int'(bus.Grant), 1 << cur.owner);
            end
            if (bus.X) begin
                xcnt++;
                gap = 0;
            end else begin
                gap++;
            end
            if (fell) begin
                chk("x_len", xcnt, cur.xlen);
                in_x      = 1'b0;
                had       = 1'b1;
                last_cool = cur.cool;
            end
            if (bt) begin
                if (bus.Busy) busy_cnt++;
                else begin
                    chk("busy_len", busy_cnt, cur.xlen + cur.cool);
                    bt = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s0;
        int    n;

        // Reset with all requesters active; first grant must go to index 0.
        Rst          = 1'b1;
        bus.Req      = '1;
        bus.OnTime   = CW'(3);
        bus.CoolTime = CW'(2);
        s0.mask = '1;
        s0.on   = 3;
        s0.cool = 2;
        model_push(s0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        wait_x(1'b1);
        @(posedge Clk); #1;
        bus.Req = '0;
        wait_idle();

        // Single requester
        add(4'b0100, 3, 2);
        run_seq();

        // Timing changed and a new requester raised during a 5-cycle burst
        add(4'b0001, 5, 0);
        add(4'b1000, 1, 0);
        run_seq();

        // Zero on-time and zero cool-down
        add(4'b0001, 0, 0);
        run_seq();

        // Reset on the second X-high cycle
        @(posedge Clk); #1;
        bus.Req      = 4'b0010;
        bus.OnTime   = CW'(4);
        bus.CoolTime = CW'(1);
        s0.mask = 4'b0010;
        s0.on   = 4;
        s0.cool = 1;
        model_push(s0);
        wait_x(1'b1);
        @(posedge Clk); #1;
        Rst     = 1'b1;
        bus.Req = '0;
        mptr    = 0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        wait_idle();

        // Round robin from a freshly reset pointer
        repeat (5) add(4'b1011, 1, 0);
        run_seq();

        repeat (30) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++)
                add(N'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 4));
            run_seq();
        end

        chk("queue_drained", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
